rx_packet_buffer: RTL and testbench

//  Link receiver at a router input port. Sits directly downstream of a packet source
//  (a test source or an upstream router output) that drives diff_pair / channel / credit.

---
 rtl/rx_packet_buffer_pkg.sv | 13 +
 rtl/rx_packet_buffer_slot_ram.sv | 22 ++
 rtl/rx_packet_buffer.sv | 138 +++++++++++++
 tb/tb_rx_packet_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_packet_buffer_pkg.sv
// Shared constants and rx FSM encoding for the router input-port packet buffer.
`timescale 1ns/1ps
package rx_packet_buffer_pkg;
   localparam int unsigned CHANNEL_WIDTH_DEF    = 32;
   localparam int unsigned FLITS_PER_PACKET_DEF = 5;
   localparam logic [1:0]  DIFF_PAIR_RESET      = 2'b10;

   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_RECV = 2'd1,
      RX_DROP = 2'd2
   } rx_state_t;
endpackage

// File: rtl/rx_packet_buffer_slot_ram.sv
// Packet slot storage: one synchronous write port, one asynchronous read port.
`timescale 1ns/1ps
module rx_packet_buffer_slot_ram #(
   parameter int unsigned DEPTH = 10,
   parameter int unsigned AW    = 4,
   parameter int unsigned DW    = 32
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);
   logic [DW-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/rx_packet_buffer.sv
// Link receiver: frames 5-flit packets from diff_pair toggles, stores them in credit
// slots and streams complete packets to the router core, returning one credit each.
`timescale 1ns/1ps
module rx_packet_buffer
   import rx_packet_buffer_pkg::*;
#(
   parameter int unsigned CREDITS       = 2,
   parameter int unsigned FLITS         = FLITS_PER_PACKET_DEF,
   parameter int unsigned CHANNEL_WIDTH = CHANNEL_WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [1:0]               diff_pair_in,
   input  logic [CHANNEL_WIDTH-1:0] channel_in,
   output logic                     credit_out,
   output logic [CHANNEL_WIDTH-1:0] flit_out,
   output logic                     flit_valid,
   output logic                     flit_last,
   input  logic                     flit_ready,
   output logic                     overflow_err,
   output logic                     framing_err
);
   localparam int unsigned PW    = (CREDITS > 1) ? $clog2(CREDITS) : 1;
   localparam int unsigned CNT_W = $clog2(CREDITS + 1);
   localparam int unsigned DEPTH = CREDITS * FLITS;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0]  LAST  = 3'(FLITS - 1);

   rx_state_t          r_state;
   logic [1:0]         r_diff_prev;
   logic [2:0]         r_wr_idx, r_rd_idx;
   logic [PW-1:0]      r_wr_slot, r_rd_slot;
   logic [CNT_W-1:0]   r_used, r_full;
   logic               r_credit, r_overflow, r_framing;

   logic               w_legal, w_start, w_abort, w_claim, w_complete;
   logic               w_valid, w_fire, w_free, w_we;
   logic [CNT_W-1:0]   w_used_base;
   logic [2:0]         w_widx;
   logic [AW-1:0]      w_waddr, w_raddr;
   logic [CHANNEL_WIDTH-1:0] w_rdata;

   // Framing and slot admission; an aborted partial packet gives its slot back first
   assign w_legal     = (diff_pair_in == 2'b01) || (diff_pair_in == 2'b10);
   assign w_start     = w_legal && (diff_pair_in != r_diff_prev);
   assign w_abort     = w_start && (r_state == RX_RECV);
   assign w_used_base = r_used - CNT_W'(w_abort);
   assign w_claim     = w_start && (w_used_base < CNT_W'(CREDITS));
   assign w_complete  = !w_start && (r_state == RX_RECV) && (r_wr_idx == LAST);

   assign w_we    = w_claim || (!w_start && (r_state == RX_RECV));
   assign w_widx  = w_start ? 3'd0 : r_wr_idx;
   assign w_waddr = AW'(r_wr_slot) * AW'(FLITS) + AW'(w_widx);
   assign w_raddr = AW'(r_rd_slot) * AW'(FLITS) + AW'(r_rd_idx);

   assign w_valid = (r_full != '0);
   assign w_fire  = w_valid && flit_ready;
   assign w_free  = w_fire && (r_rd_idx == LAST);

   rx_packet_buffer_slot_ram #(.DEPTH(DEPTH), .AW(AW), .DW(CHANNEL_WIDTH)) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (channel_in),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // Receive FSM with framing checks
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= RX_IDLE;
         r_diff_prev <= DIFF_PAIR_RESET;
         r_wr_idx    <= '0;
         r_wr_slot   <= '0;
         r_overflow  <= 1'b0;
         r_framing   <= 1'b0;
      end else begin
         if (w_legal) r_diff_prev <= diff_pair_in;
         else         r_framing   <= 1'b1;
         if (w_start) begin
            if (r_state != RX_IDLE) r_framing <= 1'b1;
            r_wr_idx <= 3'd1;
            if (w_claim) begin
               r_state <= RX_RECV;
            end else begin
               r_state    <= RX_DROP;
               r_overflow <= 1'b1;
            end
         end else begin
            case (r_state)
               RX_RECV, RX_DROP: begin
                  if (r_wr_idx == LAST) begin
                     r_wr_idx <= '0;
                     r_state  <= RX_IDLE;
                     if (r_state == RX_RECV)
                        r_wr_slot <= (r_wr_slot == PW'(CREDITS - 1)) ? '0 : r_wr_slot + PW'(1);
                  end else begin
                     r_wr_idx <= r_wr_idx + 3'd1;
                  end
               end
               RX_IDLE: r_wr_idx <= '0;
               default: r_state  <= RX_IDLE;
            endcase
         end
      end
   end

   // Slot occupancy, tx read pointer and credit return
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_used    <= '0;
         r_full    <= '0;
         r_rd_idx  <= '0;
         r_rd_slot <= '0;
         r_credit  <= 1'b0;
      end else begin
         r_used   <= r_used - CNT_W'(w_abort) + CNT_W'(w_claim) - CNT_W'(w_free);
         r_full   <= r_full + CNT_W'(w_complete) - CNT_W'(w_free);
         r_credit <= w_free;
         if (w_fire) begin
            if (r_rd_idx == LAST) begin
               r_rd_idx  <= '0;
               r_rd_slot <= (r_rd_slot == PW'(CREDITS - 1)) ? '0 : r_rd_slot + PW'(1);
            end else begin
               r_rd_idx <= r_rd_idx + 3'd1;
            end
         end
      end
   end

   assign flit_valid   = w_valid;
   assign flit_out     = w_valid ? w_rdata : '0;
   assign flit_last    = w_valid && (r_rd_idx == LAST);
   assign credit_out   = r_credit;
   assign overflow_err = r_overflow;
   assign framing_err  = r_framing;
endmodule

// File: tb/tb_rx_packet_buffer.sv
// Directed bench for rx_packet_buffer: cycle table for a single packet, then
// scoreboarded sequences for overflow, back-to-back, framing and reset cases.
`timescale 1ns/1ps
module tb_rx_packet_buffer;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  diff_pair_in;
   logic [31:0] channel_in;
   logic        credit_out;
   logic [31:0] flit_out;
   logic        flit_valid, flit_last, flit_ready;
   logic        overflow_err, framing_err;

   rx_packet_buffer #(.CREDITS(2), .FLITS(5), .CHANNEL_WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .diff_pair_in (diff_pair_in),
      .channel_in   (channel_in),
      .credit_out   (credit_out),
      .flit_out     (flit_out),
      .flit_valid   (flit_valid),
      .flit_last    (flit_last),
      .flit_ready   (flit_ready),
      .overflow_err (overflow_err),
      .framing_err  (framing_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  diff;
      logic [31:0] ch;
      logic        rdy;
      logic        valid;
      logic        last;
      logic [31:0] flit;
      logic        credit;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          credit_cnt = 0;
   int          vcnt = 0;
   int          vfirst = -1;
   int          vlast = -1;
   logic        mon_en = 1'b0;
   logic [1:0]  cur_diff;
   logic [32:0] exp_q [$];
   vec_t        tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard for accepted flits, credit pulses and flit_valid continuity
   always @(negedge clk) begin
      logic [32:0] e;
      cyc++;
      if (mon_en) begin
         if (credit_out) credit_cnt++;
         if (flit_valid) begin
            vcnt++;
            if (vfirst < 0) vfirst = cyc;
            vlast = cyc;
         end
         if (flit_valid && flit_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_flit: got %0h expected none", flit_out);
            end else begin
               e = exp_q.pop_front();
               check("flit_data", flit_out, e[31:0]);
               check("flit_last", 32'(flit_last), 32'(e[32]));
            end
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         channel_in = '0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      diff_pair_in = 2'b10;
      cur_diff = 2'b10;
      channel_in = '0;
      idle(2);
      reset = 1'b0;
      exp_q.delete();
      credit_cnt = 0;
      vcnt = 0;
      vfirst = -1;
      vlast = -1;
   endtask

   // Flip framing and drive n flits base..base+n-1; optionally expect delivery
   task automatic send_pkt(input logic [31:0] base, input int n, input bit expect_out);
      cur_diff = ~cur_diff;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         diff_pair_in = cur_diff;
         channel_in = base + 32'(i);
         if (expect_out) exp_q.push_back({(i == 4), base + 32'(i)});
      end
   endtask

   initial begin
      reset = 1'b1;
      diff_pair_in = 2'b10;
      channel_in = '0;
      flit_ready = 1'b0;
      cur_diff = 2'b10;
      #23;
      reset = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(flit_valid), 0);
      check("rst_last", 32'(flit_last), 0);
      check("rst_flit", flit_out, 0);
      check("rst_credit", 32'(credit_out), 0);
      check("rst_overflow", 32'(overflow_err), 0);
      check("rst_framing", 32'(framing_err), 0);

      // Single packet, cycle by cycle
      tbl[0]  = '{2'b01, 32'hA0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
      tbl[1]  = '{2'b01, 32'hA1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
      tbl[2]  = '{2'b01, 32'hA2, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
      tbl[3]  = '{2'b01, 32'hA3, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
      tbl[4]  = '{2'b01, 32'hA4, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
      tbl[5]  = '{2'b01, 32'h0,  1'b1, 1'b1, 1'b0, 32'hA0, 1'b0};
      tbl[6]  = '{2'b01, 32'h0,  1'b1, 1'b1, 1'b0, 32'hA1, 1'b0};
      tbl[7]  = '{2'b01, 32'h0,  1'b1, 1'b1, 1'b0, 32'hA2, 1'b0};
      tbl[8]  = '{2'b01, 32'h0,  1'b1, 1'b1, 1'b0, 32'hA3, 1'b0};
      tbl[9]  = '{2'b01, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA4, 1'b0};
      tbl[10] = '{2'b01, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1};
      tbl[11] = '{2'b01, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         diff_pair_in = tbl[i].diff;
         channel_in   = tbl[i].ch;
         flit_ready   = tbl[i].rdy;
         @(negedge clk);
         check($sformatf("t1_valid[%0d]", i), 32'(flit_valid), 32'(tbl[i].valid));
         check($sformatf("t1_last[%0d]", i), 32'(flit_last), 32'(tbl[i].last));
         check($sformatf("t1_credit[%0d]", i), 32'(credit_out), 32'(tbl[i].credit));
         if (tbl[i].valid) check($sformatf("t1_flit[%0d]", i), flit_out, tbl[i].flit);
      end
      cur_diff = 2'b01;
      mon_en = 1'b1;

      // Two packets fill both slots, third overflows and is dropped
      flit_ready = 1'b0;
      do_reset();
      send_pkt(32'hB0, 5, 1'b1);
      send_pkt(32'hC0, 5, 1'b1);
      send_pkt(32'hD0, 5, 1'b0);
      idle(2);
      @(negedge clk);
      check("t2_overflow", 32'(overflow_err), 1);
      check("t2_framing", 32'(framing_err), 0);
      check("t2_held_valid", 32'(flit_valid), 1);
      check("t2_held_flit", flit_out, 32'hB0);
      check("t2_no_credit", 32'(credit_cnt), 0);
      flit_ready = 1'b1;
      idle(20);
      @(negedge clk);
      check("t2_queue_empty", 32'(exp_q.size()), 0);
      check("t2_credits", 32'(credit_cnt), 2);
      check("t2_valid_low", 32'(flit_valid), 0);

      // Back-to-back packets stream without a bubble
      do_reset();
      flit_ready = 1'b1;
      send_pkt(32'h10, 5, 1'b1);
      send_pkt(32'h20, 5, 1'b1);
      send_pkt(32'h30, 5, 1'b1);
      idle(20);
      @(negedge clk);
      check("t3_queue_empty", 32'(exp_q.size()), 0);
      check("t3_credits", 32'(credit_cnt), 3);
      check("t3_valid_cycles", 32'(vcnt), 15);
      check("t3_contiguous", 32'(vlast - vfirst + 1), 15);
      check("t3_overflow", 32'(overflow_err), 0);

      // New packet after flit 2 aborts the partial one
      do_reset();
      send_pkt(32'hE0, 3, 1'b0);
      send_pkt(32'hF0, 5, 1'b1);
      idle(15);
      @(negedge clk);
      check("t4_framing", 32'(framing_err), 1);
      check("t4_queue_empty", 32'(exp_q.size()), 0);
      check("t4_credits", 32'(credit_cnt), 1);
      check("t4_overflow", 32'(overflow_err), 0);

      // Illegal diff_pair for one cycle
      do_reset();
      @(posedge clk); #1;
      diff_pair_in = 2'b11;
      @(posedge clk); #1;
      diff_pair_in = 2'b10;
      idle(12);
      @(negedge clk);
      check("t5_framing", 32'(framing_err), 1);
      check("t5_valid", 32'(flit_valid), 0);
      check("t5_credits", 32'(credit_cnt), 0);

      // Reset asserted during flit 3
      do_reset();
      send_pkt(32'h50, 3, 1'b0);
      @(posedge clk); #1;
      channel_in = 32'h53;
      reset = 1'b1;
      @(negedge clk);
      check("t6_valid", 32'(flit_valid), 0);
      check("t6_last", 32'(flit_last), 0);
      check("t6_flit", flit_out, 0);
      check("t6_credit", 32'(credit_out), 0);
      check("t6_errors", {30'd0, overflow_err, framing_err}, 0);
      do_reset();
      send_pkt(32'h60, 5, 1'b1);
      idle(15);
      @(negedge clk);
      check("t6_queue_empty", 32'(exp_q.size()), 0);
      check("t6_credits", 32'(credit_cnt), 1);
      check("t6_framing", 32'(framing_err), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
